// File: rtl/ym_glue_pkg.sv
// Shared constants and types for the multi-YM2149 Spectrum bus glue.
package ym_glue_pkg;
    localparam logic [5:0] AY_SEL_PREFIX    = 6'b111111;
    localparam logic [7:0] COVOX_PORT       = 8'hFB;
    localparam int         TURBO_THRESH_DEF = 100000;

    typedef logic [1:0] sel_idx_t;
endpackage

// File: rtl/ym_clk_gen.sv
// YM master clock generator: INT synchroniser, frame-length counter, turbo
// detection and a divider whose ratio only changes at a full period boundary.
module ym_clk_gen
    import ym_glue_pkg::*;
#(
    parameter int TURBO_THRESH = TURBO_THRESH_DEF,
    parameter int CNT_W        = 18
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_int,
    output logic o_ym_clock,
    output logic o_turbo
);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(TURBO_THRESH);

    logic             r_sync1, r_sync2, r_sync3;
    logic [CNT_W-1:0] r_fcnt;
    logic             r_turbo, r_mode_pend, r_mode;
    logic [1:0]       r_div;
    logic             r_ym_clock;

    logic       w_int_fall;
    logic       w_over;
    logic       w_mode_nxt;
    logic [1:0] w_div_nxt;

    assign w_int_fall = r_sync3 & ~r_sync2;
    assign w_over     = (r_fcnt > THRESH_C) | (&r_fcnt);
    assign w_div_nxt  = r_div + 2'd1;
    // Ratio switches only as div wraps, so both halves of every period are whole.
    assign w_mode_nxt = (r_div == 2'b11) ? r_mode_pend : r_mode;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync3     <= 1'b1;
            r_fcnt      <= '0;
            r_turbo     <= 1'b0;
            r_mode_pend <= 1'b0;
            r_mode      <= 1'b0;
            r_div       <= 2'b00;
            r_ym_clock  <= 1'b0;
        end else begin
            r_sync1 <= i_int;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (w_int_fall) begin
                r_turbo     <= w_over;
                r_mode_pend <= w_over;
                r_fcnt      <= '0;
            end else if (!(&r_fcnt)) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
            r_div      <= w_div_nxt;
            r_mode     <= w_mode_nxt;
            r_ym_clock <= w_mode_nxt ? w_div_nxt[1] : w_div_nxt[0];
        end
    end

    assign o_ym_clock = r_ym_clock;
    assign o_turbo    = r_turbo;
endmodule

// File: rtl/ym_multi_glue.sv
// ZX Spectrum glue for 1..4 YM2149/AY chips: AY port decode, chip select, YM clock.
// Define COVOX_EN to add an 8-bit Covox DAC latch on port #FB (full low address byte).
module ym_multi_glue
    import ym_glue_pkg::*;
#(
    parameter int NUM_CHIPS    = 2,
    parameter int TURBO_THRESH = TURBO_THRESH_DEF,
    parameter int CNT_W        = 18
) (
    input  logic                 i_cpu_clock,
    input  logic                 i_reset,
    input  logic                 i_a15,
    input  logic                 i_a14,
`ifdef COVOX_EN
    input  logic [7:0]           i_a_lo,
`else
    input  logic                 i_a1,
`endif
    input  logic                 i_iorq,
    input  logic                 i_wr,
    input  logic                 i_rd,
    input  logic                 i_m1,
    input  logic                 i_int,
    input  logic [7:0]           i_d,
    output logic                 o_bc1,
    output logic                 o_bdir,
    output logic [NUM_CHIPS-1:0] o_ym_sel,
    output logic                 o_ym_clock,
    output logic                 o_turbo
`ifdef COVOX_EN
   ,output logic [7:0]           o_covox
`endif
);
    logic     w_a1;
    logic     w_io_cyc;
    logic     w_ay_port;
    logic     w_sel_cmd;
    sel_idx_t w_sel_code;
    sel_idx_t r_sel_idx;

`ifdef COVOX_EN
    assign w_a1 = i_a_lo[1];
`else
    assign w_a1 = i_a1;
`endif

    assign w_io_cyc   = ~i_iorq & i_m1;
    assign w_ay_port  = w_io_cyc & i_a15 & ~w_a1;
    assign w_sel_code = ~i_d[1:0];
    // Select codes for absent chips fall through as ordinary register-select writes.
    assign w_sel_cmd  = w_ay_port & i_a14 & ~i_wr & (i_d[7:2] == AY_SEL_PREFIX)
                        & (int'(w_sel_code) < NUM_CHIPS);

    assign o_bdir = w_ay_port & ~i_wr & ~w_sel_cmd;
    assign o_bc1  = w_ay_port & i_a14 & (~i_wr | ~i_rd) & ~w_sel_cmd;

    always_ff @(posedge i_cpu_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_sel_idx <= '0;
        end else if (w_sel_cmd) begin
            r_sel_idx <= w_sel_code;
        end
    end

    for (genvar g = 0; g < NUM_CHIPS; g++) begin : g_sel
        assign o_ym_sel[g] = (r_sel_idx != sel_idx_t'(g));
    end

`ifdef COVOX_EN
    logic [7:0] r_covox;

    always_ff @(posedge i_cpu_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_covox <= 8'h00;
        end else if (w_io_cyc & ~i_wr & (i_a_lo == COVOX_PORT)) begin
            r_covox <= i_d;
        end
    end

    assign o_covox = r_covox;
`endif

    ym_clk_gen #(
        .TURBO_THRESH (TURBO_THRESH),
        .CNT_W        (CNT_W)
    ) u_clk_gen (
        .i_clk      (i_cpu_clock),
        .i_rst_n    (i_reset),
        .i_int      (i_int),
        .o_ym_clock (o_ym_clock),
        .o_turbo    (o_turbo)
    );
endmodule

// File: tb/tb_ym_multi_glue.sv
// Bench for ym_multi_glue with a short frame threshold so turbo detection runs quickly.
module tb_ym_multi_glue;
    localparam int NC = 2;
    localparam int TH = 100;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n, a15, a14, a1, iorq, wr, rd, m1, int_n;
    logic [7:0]    d;
    logic          bc1, bdir, ym_clock, turbo;
    logic [NC-1:0] ym_sel;
    int            vectors = 0;
    int            errors  = 0;
    int            m_sel   = 0;

    always #5 clk = ~clk;

`ifdef COVOX_EN
    logic       cov_addr = 1'b0;
    logic [7:0] covox;
    logic [7:0] a_lo;
    assign a_lo = cov_addr ? 8'hFB : {6'b000000, a1, 1'b0};
`endif

    ym_multi_glue #(.NUM_CHIPS(NC), .TURBO_THRESH(TH), .CNT_W(CW)) dut (
        .i_cpu_clock (clk),
        .i_reset     (rst_n),
        .i_a15       (a15),
        .i_a14       (a14),
`ifdef COVOX_EN
        .i_a_lo      (a_lo),
`else
        .i_a1        (a1),
`endif
        .i_iorq      (iorq),
        .i_wr        (wr),
        .i_rd        (rd),
        .i_m1        (m1),
        .i_int       (int_n),
        .i_d         (d),
        .o_bc1       (bc1),
        .o_bdir      (bdir),
        .o_ym_sel    (ym_sel),
        .o_ym_clock  (ym_clock),
        .o_turbo     (turbo)
`ifdef COVOX_EN
       ,.o_covox     (covox)
`endif
    );

    // Bus model: classify the access by port, then apply the AY truth table.
    function automatic void bus_model(output logic e_bdir, output logic e_bc1,
                                      output logic e_is_sel);
        bit is_ay   = !iorq && m1 && a15 && !a1;
        bit is_fffd = is_ay && a14;
        bit is_bffd = is_ay && !a14;
        e_is_sel = is_fffd && !wr && (d >= 8'hFC) && ((255 - int'(d)) < NC);
        e_bdir = 1'b0;
        e_bc1  = 1'b0;
        if (is_bffd && !wr) e_bdir = 1'b1;
        if (is_fffd && !e_is_sel) begin
            if (!wr) begin
                e_bdir = 1'b1;
                e_bc1  = 1'b1;
            end else if (!rd) begin
                e_bc1 = 1'b1;
            end
        end
    endfunction

    function automatic logic [NC-1:0] sel_model(input int idx);
        logic [NC-1:0] v = '1;
        v[idx] = 1'b0;
        return v;
    endfunction

    // Frame length seen by the counter is the gap minus one, capped at all-ones.
    function automatic logic turbo_model(input int gap);
        int f = gap - 1;
        if (f > (1 << CW) - 1) f = (1 << CW) - 1;
        return (f > TH);
    endfunction

    task automatic bus_idle();
        iorq = 1'b1; wr = 1'b1; rd = 1'b1; m1 = 1'b1;
        a15 = 1'b0; a14 = 1'b0; a1 = 1'b0; d = 8'h00;
    endtask

    task automatic bus_set(input logic p_a15, input logic p_a14, input logic p_a1,
                           input logic p_wr, input logic p_rd, input logic p_m1,
                           input logic [7:0] p_d);
        iorq = 1'b0; a15 = p_a15; a14 = p_a14; a1 = p_a1;
        wr = p_wr; rd = p_rd; m1 = p_m1; d = p_d;
    endtask

    // One bus cycle: check strobes mid-cycle, clock it, then check chip select.
    task automatic bus_cycle(input string name);
        logic e_bdir, e_bc1, e_sel;
        @(negedge clk);
        #1;
        bus_model(e_bdir, e_bc1, e_sel);
        vectors++;
        if ({bdir, bc1} !== {e_bdir, e_bc1}) begin
            errors++;
            $display("FAIL %s strobes: got bdir/bc1=%b%b want %b%b (d=%h)", name, bdir, bc1, e_bdir, e_bc1, d);
        end
        @(posedge clk);
        if (e_sel) m_sel = 255 - int'(d);
        #1;
        vectors++;
        if (ym_sel !== sel_model(m_sel)) begin
            errors++;
            $display("FAIL %s ym_sel: got %b want %b", name, ym_sel, sel_model(m_sel));
        end
    endtask

    task automatic run_frames(input int period, input int n);
        repeat (n) begin
            @(negedge clk) int_n = 1'b0;
            repeat (3) @(negedge clk);
            int_n = 1'b1;
            repeat (period - 4) @(negedge clk);
        end
    endtask

    task automatic check_turbo(input string name, input logic exp);
        vectors++;
        if (turbo !== exp) begin
            errors++;
            $display("FAIL %s turbo: got %b want %b", name, turbo, exp);
        end
    endtask

    task automatic check_ym_period(input string name, input int half);
        int run = 0, nruns = 0, bad = 0;
        logic prev;
        repeat (8) @(negedge clk);
        prev = ym_clock;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (ym_clock === prev) begin
                run++;
            end else begin
                if (nruns > 0 && run + 1 != half) bad++;
                nruns++;
                run = 0;
                prev = ym_clock;
            end
        end
        vectors++;
        if (bad != 0 || nruns < 4) begin
            errors++;
            $display("FAIL %s ym_clock: %0d bad phases of %0d, want every phase %0d cycles", name, bad, nruns, half);
        end
    endtask

    task automatic test_reset();
        bus_idle();
        int_n = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if ({ym_sel, turbo, ym_clock, bdir, bc1} !== {sel_model(0), 4'b0000}) begin
            errors++;
            $display("FAIL reset state: got sel=%b t=%b yc=%b bd=%b bc=%b want sel=%b rest 0",
                     ym_sel, turbo, ym_clock, bdir, bc1, sel_model(0));
        end
        @(negedge clk) rst_n = 1'b1;
        m_sel = 0;
    endtask

    task automatic test_directed_bus();
        bus_set(1, 1, 0, 0, 1, 1, 8'hFE); bus_cycle("sel_fe");
        bus_set(1, 1, 0, 0, 1, 1, 8'h07); bus_cycle("reg_07");
        bus_set(1, 0, 0, 0, 1, 1, 8'hAA); bus_cycle("bffd_aa");
        bus_set(1, 1, 0, 1, 0, 1, 8'h00); bus_cycle("fffd_rd");
        bus_set(1, 1, 0, 0, 1, 0, 8'hFF); bus_cycle("m1_low");
        bus_set(1, 1, 0, 0, 1, 1, 8'hFD); bus_cycle("sel_fd_absent");
        bus_set(1, 1, 0, 0, 1, 1, 8'hFF); bus_cycle("sel_ff");
        bus_idle();
    endtask

    task automatic test_random_bus();
        for (int i = 0; i < 150; i++) begin
            iorq = ($urandom_range(0, 3) == 0);
            m1   = ($urandom_range(0, 5) != 0);
            a15  = ($urandom_range(0, 4) != 0);
            a14  = 1'($urandom);
            a1   = ($urandom_range(0, 3) == 0);
            wr   = 1'($urandom);
            rd   = 1'($urandom);
            d    = $urandom_range(0, 1) ? 8'(8'hFC + $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            bus_cycle("rand_bus");
        end
        bus_idle();
    endtask

    task automatic test_turbo_detect();
        repeat (300) @(negedge clk);
        run_frames(70, 1);
        check_turbo("first_from_reset", turbo_model(300));
        run_frames(70, 3);
        check_turbo("frames_3m5", turbo_model(70));
        check_ym_period("normal", 1);
        run_frames(140, 2);
        check_turbo("frames_7m", turbo_model(140));
        check_ym_period("turbo", 2);
        run_frames(TH + 1, 2);
        check_turbo("at_thresh", turbo_model(TH + 1));
        run_frames(TH + 2, 2);
        check_turbo("above_thresh", turbo_model(TH + 2));
        for (int i = 0; i < 6; i++) begin
            int p = $urandom_range(20, 300);
            run_frames(p, 2);
            check_turbo("rand_frame", turbo_model(p));
        end
    endtask

    task automatic test_int_held_low();
        run_frames(70, 2);
        check_turbo("before_hold", turbo_model(70));
        @(negedge clk) int_n = 1'b0;
        repeat (249) @(negedge clk);
        check_turbo("during_hold", turbo_model(70));
        int_n = 1'b1;
        repeat (10) @(negedge clk);
        int_n = 1'b0;
        repeat (6) @(negedge clk);
        int_n = 1'b1;
        check_turbo("after_hold", turbo_model(260));
    endtask

    task automatic test_reset_midframe();
        run_frames(140, 2);
        bus_set(1, 1, 0, 0, 1, 1, 8'hFE); bus_cycle("sel_before_rst");
        check_turbo("turbo_before_rst", turbo_model(140));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ym_sel, turbo, ym_clock} !== {sel_model(0), 2'b00}) begin
            errors++;
            $display("FAIL mid_reset: got sel=%b t=%b yc=%b want sel=%b t=0 yc=0", ym_sel, turbo, ym_clock, sel_model(0));
        end
        bus_set(1, 1, 0, 0, 1, 1, 8'h07);
        #1;
        vectors++;
        if ({bdir, bc1} !== 2'b11) begin
            errors++;
            $display("FAIL rst_reg_write: got bdir/bc1=%b%b want 11", bdir, bc1);
        end
        bus_set(1, 1, 0, 0, 1, 1, 8'hFE);
        #1;
        vectors++;
        if ({bdir, bc1} !== 2'b00) begin
            errors++;
            $display("FAIL rst_sel_mask: got bdir/bc1=%b%b want 00", bdir, bc1);
        end
        bus_idle();
        @(negedge clk) rst_n = 1'b1;
        m_sel = 0;
        bus_set(1, 1, 0, 0, 1, 1, 8'h07); bus_cycle("after_rst");
        bus_idle();
    endtask

`ifdef COVOX_EN
    task automatic test_covox();
        @(negedge clk);
        cov_addr = 1'b1;
        iorq = 1'b0; m1 = 1'b1; wr = 1'b0; d = 8'h5A;
        @(posedge clk);
        #1;
        vectors++;
        if (covox !== 8'h5A) begin
            errors++;
            $display("FAIL covox: got %h want 5a", covox);
        end
        @(negedge clk);
        cov_addr = 1'b0;
        bus_idle();
    endtask
`endif

    initial begin
        test_reset();
        test_directed_bus();
        test_random_bus();
        test_turbo_detect();
        test_int_held_low();
        test_reset_midframe();
`ifdef COVOX_EN
        test_covox();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
